// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter feeding one UART transmitter; the grant is locked per message.
// Define UART_ARB_TIMEOUT_EN to release a locked grant after TIMEOUT idle cycles in HOLD.
module uart_tx_arb #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_req0_valid,
    input  logic          i_req1_valid,
    input  logic [DW-1:0] i_req0_data,
    input  logic [DW-1:0] i_req1_data,
    input  logic          i_req0_last,
    input  logic          i_req1_last,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_start,
    input  logic          i_tx_busy,
    output logic [1:0]    o_grant
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, HOLD} state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_grant, w_grant;
    logic [DW-1:0] r_data, w_data;
    logic          r_last, w_last;
    logic          r_pri, w_pri;
    logic          w_gvalid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt, w_cnt;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) r_cnt <= '0;
        else          r_cnt <= w_cnt;
    end
`else
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end
`endif

    assign w_gvalid     = |(r_grant & {i_req1_valid, i_req0_valid});
    assign o_req0_ready = (r_state == LOAD) && r_grant[0] && i_req0_valid;
    assign o_req1_ready = (r_state == LOAD) && r_grant[1] && i_req1_valid;
    assign o_tx_start   = (r_state == START);
    assign o_tx_data    = r_data;
    assign o_grant      = r_grant;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_pri   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_data  <= w_data;
            r_last  <= w_last;
            r_pri   <= w_pri;
        end
    end

    // r_pri=1 means req1 wins the next tie; it flips to the other side of whoever just finished.
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_data  = r_data;
        w_last  = r_last;
        w_pri   = r_pri;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt   = r_cnt;
`endif
        case (r_state)
            IDLE: if (i_req0_valid || i_req1_valid) begin
                w_grant = (i_req0_valid && !(i_req1_valid && r_pri)) ? 2'b01 : 2'b10;
                w_state = LOAD;
            end
            LOAD: if (w_gvalid) begin
                w_data  = r_grant[0] ? i_req0_data : i_req1_data;
                w_last  = r_grant[0] ? i_req0_last : i_req1_last;
                w_state = START;
            end
            START:    w_state = WAIT_ACK;
            WAIT_ACK: if (i_tx_busy) w_state = WAIT_DONE;
            WAIT_DONE: if (!i_tx_busy) begin
                if (r_last) begin
                    w_state = IDLE;
                    w_grant = '0;
                    w_pri   = r_grant[0];
                end else begin
                    w_state = HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt   = '0;
`endif
                end
            end
            HOLD: if (w_gvalid) begin
                w_state = LOAD;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (r_cnt == CW'(TIMEOUT - 1)) begin
                w_state = IDLE;
                w_grant = '0;
                w_pri   = r_grant[0];
            end else begin
                w_cnt   = r_cnt + CW'(1);
            end
`endif
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with a small UART busy model.
// Expected {grant, byte} pairs are queued at stimulus time and popped on each o_tx_start.
module tb_uart_tx_arb;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [DW-1:0] i_req0_data = '0, i_req1_data = '0;
    logic          i_req0_last = 1'b0, i_req1_last = 1'b0;
    logic          o_req0_ready, o_req1_ready;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_start;
    logic          i_tx_busy = 1'b0;
    logic [1:0]    o_grant;

    int         n_total = 0;
    int         n_bad = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_arb #(.DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
        .i_req0_data(i_req0_data), .i_req1_data(i_req1_data),
        .i_req0_last(i_req0_last), .i_req1_last(i_req1_last),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_tx_busy(i_tx_busy), .o_grant(o_grant)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises one cycle after the start pulse and lasts four cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                @(posedge clk);
                #1 i_tx_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1 i_tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [9:0] e;
        logic       prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (o_req0_ready) chk("ready0_owner", o_grant, 2'b01);
            if (o_req1_ready) chk("ready1_owner", o_grant, 2'b10);
            if (o_tx_start) begin
                chk("start_width", prev_start, 0);
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_start: got %0h grant %0b want no start", o_tx_data, o_grant);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", o_tx_data, e[7:0]);
                    chk("tx_grant", o_grant, e[9:8]);
                end
            end
            prev_start = o_tx_start;
        end
    end

    task automatic send(input bit who, input logic [7:0] d, input bit last);
        int n = 0;
        @(negedge clk);
        if (who) begin i_req1_valid = 1'b1; i_req1_data = d; i_req1_last = last; end
        else     begin i_req0_valid = 1'b1; i_req0_data = d; i_req0_last = last; end
        while (!(who ? o_req1_ready : o_req0_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", n < 300, 1);
        @(negedge clk);
        if (who) i_req1_valid = 1'b0;
        else     i_req0_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_grant != 2'b00 || i_tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 500, 1);
    endtask

    task automatic wait_busy(input bit level, input string name);
        int n = 0;
        while (i_tx_busy != level && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 100, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with both valids high: nothing may be readied.
        i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_req0_data = 8'hEE; i_req1_data = 8'hEE;
        #12;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_start", o_tx_start, 0);
        chk("rst_ready0", o_req0_ready, 0);
        chk("rst_ready1", o_req1_ready, 0);
        chk("rst_data", o_tx_data, 8'h00);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        @(negedge clk) i_reset = 1'b1;

        // Single byte with exact latency.
        sb.push_back({2'b01, 8'h41});
        @(negedge clk);
        i_req0_valid = 1'b1; i_req0_data = 8'h41; i_req0_last = 1'b1;
        @(negedge clk);
        chk("t1_ready0", o_req0_ready, 1);
        chk("t1_grant", o_grant, 2'b01);
        @(negedge clk);
        chk("t1_start", o_tx_start, 1);
        chk("t1_data", o_tx_data, 8'h41);
        i_req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_start_pulse", o_tx_start, 0);
        wait_idle("t1_idle");
        chk("t1_grant_clear", o_grant, 2'b00);
        chk("t1_data_hold", o_tx_data, 8'h41);

        // Fresh reset, then a tie: req0 wins first.
        @(negedge clk) i_reset = 1'b0;
        @(negedge clk) i_reset = 1'b1;
        sb.push_back({2'b01, 8'hA0});
        sb.push_back({2'b10, 8'hB0});
        fork
            send(0, 8'hA0, 1);
            send(1, 8'hB0, 1);
        join
        wait_idle("t2_idle");

        // req0 alone, so the following tie must go to req1.
        sb.push_back({2'b01, 8'h11});
        send(0, 8'h11, 1);
        wait_idle("t3_idle");
        sb.push_back({2'b10, 8'hD0});
        sb.push_back({2'b01, 8'hC0});
        fork
            send(0, 8'hC0, 1);
            send(1, 8'hD0, 1);
        join
        wait_idle("t4_idle");

        // Locked three-byte message from req0 while req1 waits with 0x55.
        sb.push_back({2'b01, 8'h01});
        sb.push_back({2'b01, 8'h02});
        sb.push_back({2'b01, 8'h03});
        sb.push_back({2'b10, 8'h55});
        fork
            begin
                send(0, 8'h01, 0);
                repeat (8) @(negedge clk);
                chk("lock_grant_a", o_grant, 2'b01);
                chk("lock_ready1_a", o_req1_ready, 0);
                repeat (2) @(negedge clk);
                send(0, 8'h02, 0);
                repeat (10) @(negedge clk);
                chk("lock_grant_b", o_grant, 2'b01);
                send(0, 8'h03, 1);
            end
            begin
                repeat (2) @(negedge clk);
                send(1, 8'h55, 1);
            end
        join
        wait_idle("t5_idle");

        // req0 leaves a message open and goes quiet while req1 has 0x20 pending.
        sb.push_back({2'b01, 8'h10});
`ifndef UART_ARB_TIMEOUT_EN
        sb.push_back({2'b01, 8'h12});
`endif
        sb.push_back({2'b10, 8'h20});
        fork
            begin
                send(0, 8'h10, 0);
                wait_busy(1, "t6_busy_rise");
                wait_busy(0, "t6_busy_fall");
                repeat (16) @(negedge clk);
                chk("hold_grant_15", o_grant, 2'b01);
`ifdef UART_ARB_TIMEOUT_EN
                @(negedge clk);
                chk("timeout_release", o_grant, 2'b00);
                @(negedge clk);
                chk("timeout_regrant", o_grant, 2'b10);
`else
                repeat (24) @(negedge clk);
                chk("hold_grant_40", o_grant, 2'b01);
                chk("hold_ready1", o_req1_ready, 0);
                send(0, 8'h12, 1);
`endif
            end
            begin
                repeat (2) @(negedge clk);
                send(1, 8'h20, 1);
            end
        join
        wait_idle("t6_idle");

        // Reset during WAIT_DONE abandons the message.
        sb.push_back({2'b01, 8'h66});
        send(0, 8'h66, 0);
        wait_busy(1, "t7_busy_rise");
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("midrst_grant", o_grant, 2'b00);
        chk("midrst_start", o_tx_start, 0);
        chk("midrst_ready0", o_req0_ready, 0);
        chk("midrst_data", o_tx_data, 8'h00);
        wait_busy(0, "t7_busy_fall");
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        sb.push_back({2'b01, 8'h77});
        send(0, 8'h77, 1);
        wait_idle("t7_idle");
        chk("final_data", o_tx_data, 8'h77);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
